// File: rtl/maze_pkg.sv
// Shared encodings for the maze game controller and its move unit.
// State and direction codes, start cell and goal helper.
package maze_pkg;

   localparam logic [1:0] ST_WELCOME = 2'd0;
   localparam logic [1:0] ST_GEN     = 2'd1;
   localparam logic [1:0] ST_PLAY    = 2'd2;
   localparam logic [1:0] ST_WIN     = 2'd3;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   localparam int START_X = 1;
   localparam int START_Y = 1;

   function automatic int goal_coord(input int dim);
      return dim - 2;
   endfunction

endpackage

// File: rtl/maze_move_unit.sv
// Player movement: auto-repeat timing, direction priority,
// bounds/wall check against the locked map, position and step count.
module maze_move_unit
   import maze_pkg::*;
#(
   parameter int MAZE_DIM   = 19,
   parameter int POS_W      = 5,
   parameter int MOVE_TICKS = 50_000_000
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         en_i,
   input  logic                         load_i,
   input  logic [MAZE_DIM*MAZE_DIM-1:0] map_i,
   input  logic                         up_i,
   input  logic                         down_i,
   input  logic                         left_i,
   input  logic                         right_i,
   output logic [POS_W-1:0]             pos_x_o,
   output logic [POS_W-1:0]             pos_y_o,
   output logic [15:0]                  step_cnt_o
);

   localparam int CNT_W = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
   localparam int IDX_W = $clog2(MAZE_DIM * MAZE_DIM);
   localparam logic [POS_W-1:0] LAST   = POS_W'(MAZE_DIM - 1);
   localparam logic [POS_W-1:0] X0     = POS_W'(START_X);
   localparam logic [POS_W-1:0] Y0     = POS_W'(START_Y);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MOVE_TICKS - 1);

   logic [POS_W-1:0] x_q, x_d, y_q, y_d;
   logic [POS_W-1:0] tx, ty;
   logic [15:0]      step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx;
   logic             inb, ok;
   dir_e             dir;

   always_comb begin
      dir = DIR_NONE;
      priority case (1'b1)
         up_i:    dir = DIR_UP;
         down_i:  dir = DIR_DOWN;
         left_i:  dir = DIR_LEFT;
         right_i: dir = DIR_RIGHT;
         default: dir = DIR_NONE;
      endcase
   end

   always_comb begin
      tx  = x_q;
      ty  = y_q;
      inb = 1'b0;
      unique case (dir)
         DIR_UP: begin
            inb = (y_q != '0);
            ty  = y_q - 1'b1;
         end
         DIR_DOWN: begin
            inb = (y_q != LAST);
            ty  = y_q + 1'b1;
         end
         DIR_LEFT: begin
            inb = (x_q != '0);
            tx  = x_q - 1'b1;
         end
         DIR_RIGHT: begin
            inb = (x_q != LAST);
            tx  = x_q + 1'b1;
         end
         default: inb = 1'b0;
      endcase
      idx = IDX_W'(ty) * IDX_W'(MAZE_DIM) + IDX_W'(tx);
      ok  = inb && !map_i[idx];
   end

   // Rejected attempts still reload, so bumping a wall paces like a move.
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      step_d = step_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         x_d    = X0;
         y_d    = Y0;
         step_d = '0;
         cnt_d  = '0;
      end else if (!en_i || dir == DIR_NONE) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = RELOAD;
         if (ok) begin
            x_d = tx;
            y_d = ty;
            if (step_q != '1) step_d = step_q + 16'd1;
         end
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q    <= X0;
         y_q    <= Y0;
         step_q <= '0;
         cnt_q  <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         step_q <= step_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pos_x_o    = x_q;
   assign pos_y_o    = y_q;
   assign step_cnt_o = step_q;

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game flow: WELCOME/GEN/PLAY/WIN, size select, regen request,
// map lock, play timer; movement delegated to maze_move_unit.
module maze_game_ctrl
   import maze_pkg::*;
#(
   parameter int MAZE_DIM   = 19,
   parameter int POS_W      = 5,
   parameter int MOVE_TICKS = 50_000_000,
   parameter int SEC_TICKS  = 100_000_000,
   parameter int NUM_MIN    = 1,
   parameter int NUM_MAX    = 20
) (
   input  logic                         clk,
   input  logic                         rst_sys,
   input  logic                         key_up,
   input  logic                         key_down,
   input  logic                         key_left,
   input  logic                         key_right,
   input  logic                         key_enter,
   input  logic [MAZE_DIM*MAZE_DIM-1:0] map,
   input  logic                         map_valid,
   output logic [1:0]                   state,
   output logic [4:0]                   num,
   output logic                         regen,
   output logic                         map_locked,
   output logic [POS_W-1:0]             pos_x,
   output logic [POS_W-1:0]             pos_y,
   output logic [15:0]                  step_cnt,
   output logic [11:0]                  play_sec,
   output logic                         win
);

   localparam int MAP_W = MAZE_DIM * MAZE_DIM;
   localparam int SEC_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
   localparam logic [POS_W-1:0] GOAL  = POS_W'(goal_coord(MAZE_DIM));
   localparam logic [4:0]       N_MIN = 5'(NUM_MIN);
   localparam logic [4:0]       N_MAX = 5'(NUM_MAX);
   localparam logic [SEC_W-1:0] S_END = SEC_W'(SEC_TICKS - 1);

   logic [1:0]       state_q, state_d;
   logic [4:0]       num_q, num_d;
   logic             regen_q, regen_d;
   logic             win_q, win_d;
   logic [4:0]       key_q, keys, press;
   logic             armed_q;
   logic [MAP_W-1:0] map_q, map_d;
   logic [SEC_W-1:0] tick_q, tick_d;
   logic [11:0]      sec_q, sec_d;
   logic             load, play_en, at_goal;

   // armed_q masks the first sampled cycle so keys held through reset are not presses.
   assign keys  = {key_enter, key_right, key_left, key_down, key_up};
   assign press = armed_q ? (keys & ~key_q) : 5'd0;

   always_ff @(posedge clk or negedge rst_sys) begin
      if (!rst_sys) begin
         state_q <= ST_WELCOME;
         num_q   <= N_MIN;
         regen_q <= 1'b0;
         win_q   <= 1'b0;
         key_q   <= '0;
         armed_q <= 1'b0;
         map_q   <= '0;
         tick_q  <= '0;
         sec_q   <= '0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         regen_q <= regen_d;
         win_q   <= win_d;
         key_q   <= keys;
         armed_q <= 1'b1;
         map_q   <= map_d;
         tick_q  <= tick_d;
         sec_q   <= sec_d;
      end
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      regen_d = 1'b0;
      win_d   = 1'b0;
      map_d   = map_q;
      load    = 1'b0;
      unique case (state_q)
         ST_WELCOME: begin
            if (press[4]) begin
               regen_d = 1'b1;
               state_d = ST_GEN;
            end else if (press[0]) begin
               if (num_q != N_MAX) num_d = num_q + 5'd1;
            end else if (press[1]) begin
               if (num_q != N_MIN) num_d = num_q - 5'd1;
            end
         end
         ST_GEN: begin
            if (press[4]) begin
               regen_d = 1'b1;
            end else if (|press[3:0] && map_valid) begin
               map_d   = map;
               load    = 1'b1;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (at_goal) begin
               win_d   = 1'b1;
               state_d = ST_WIN;
            end
         end
         ST_WIN: begin
            if (press[4]) begin
               regen_d = 1'b1;
               state_d = ST_GEN;
            end
         end
         default: state_d = ST_WELCOME;
      endcase
   end

   always_comb begin
      tick_d = tick_q;
      sec_d  = sec_q;
      if (load) begin
         tick_d = '0;
         sec_d  = '0;
      end else if (play_en) begin
         if (tick_q == S_END) begin
            tick_d = '0;
            if (sec_q != '1) sec_d = sec_q + 12'd1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   always_comb begin
      map_locked = (state_q == ST_PLAY) || (state_q == ST_WIN);
      play_en    = (state_q == ST_PLAY) && !at_goal;
      at_goal    = (pos_x == GOAL) && (pos_y == GOAL);
      state      = state_q;
      num        = num_q;
      regen      = regen_q;
      win        = win_q;
      play_sec   = sec_q;
   end

   maze_move_unit #(
      .MAZE_DIM   (MAZE_DIM),
      .POS_W      (POS_W),
      .MOVE_TICKS (MOVE_TICKS)
   ) u_move (
      .clk_i      (clk),
      .rst_ni     (rst_sys),
      .en_i       (play_en),
      .load_i     (load),
      .map_i      (map_q),
      .up_i       (key_up),
      .down_i     (key_down),
      .left_i     (key_left),
      .right_i    (key_right),
      .pos_x_o    (pos_x),
      .pos_y_o    (pos_y),
      .step_cnt_o (step_cnt)
   );

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl on a 5x5 corridor map:
// a vector table for the main flow plus hand-written corner sequences.
module tb_maze_game_ctrl;

   localparam int DIM = 5;
   localparam int PW  = 5;

   localparam logic [4:0] N = 5'b00000;
   localparam logic [4:0] U = 5'b00001;
   localparam logic [4:0] D = 5'b00010;
   localparam logic [4:0] R = 5'b01000;
   localparam logic [4:0] E = 5'b10000;

   typedef struct {
      logic [4:0]  k;
      logic        mv;
      logic [1:0]  st;
      logic [4:0]  num;
      logic        rg;
      logic        lk;
      logic [4:0]  x;
      logic [4:0]  y;
      logic [15:0] step;
      logic [11:0] sec;
      logic        win;
   } vec_t;

   logic clk, rst_sys;
   logic key_up, key_down, key_left, key_right, key_enter;
   logic [DIM*DIM-1:0] map, corridor;
   logic map_valid;
   logic [1:0] state;
   logic [4:0] num;
   logic regen, map_locked, win;
   logic [PW-1:0] pos_x, pos_y;
   logic [15:0] step_cnt;
   logic [11:0] play_sec;

   int checks = 0;
   int errors = 0;
   vec_t tv[$];

   maze_game_ctrl #(
      .MAZE_DIM   (DIM),
      .POS_W      (PW),
      .MOVE_TICKS (4),
      .SEC_TICKS  (8),
      .NUM_MIN    (1),
      .NUM_MAX    (20)
   ) dut (
      .clk        (clk),
      .rst_sys    (rst_sys),
      .key_up     (key_up),
      .key_down   (key_down),
      .key_left   (key_left),
      .key_right  (key_right),
      .key_enter  (key_enter),
      .map        (map),
      .map_valid  (map_valid),
      .state      (state),
      .num        (num),
      .regen      (regen),
      .map_locked (map_locked),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .step_cnt   (step_cnt),
      .play_sec   (play_sec),
      .win        (win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] k, input logic mv);
      key_up    = k[0];
      key_down  = k[1];
      key_left  = k[2];
      key_right = k[3];
      key_enter = k[4];
      map_valid = mv;
   endtask

   task automatic tick(input logic [4:0] k, input logic mv);
      drive(k, mv);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [4:0] k, input logic mv,
                      input logic [1:0] st, input logic [4:0] n,
                      input logic rg, input logic lk,
                      input logic [4:0] x, input logic [4:0] y,
                      input logic [15:0] s, input logic [11:0] sec,
                      input logic w);
      vec_t v;
      v.k = k;   v.mv = mv; v.st = st; v.num = n;  v.rg = rg;
      v.lk = lk; v.x = x;   v.y = y;   v.step = s; v.sec = sec;
      v.win = w;
      tv.push_back(v);
   endtask

   task automatic chk_pos(input string tag, input logic [1:0] st,
                          input logic [4:0] x, input logic [4:0] y,
                          input logic [15:0] s);
      chk({tag, " state"}, 32'(state), 32'(st));
      chk({tag, " x"}, 32'(pos_x), 32'(x));
      chk({tag, " y"}, 32'(pos_y), 32'(y));
      chk({tag, " step"}, 32'(step_cnt), 32'(s));
   endtask

   initial begin
      corridor = '1;
      corridor[1*DIM+1] = 1'b0;
      corridor[1*DIM+2] = 1'b0;
      corridor[1*DIM+3] = 1'b0;
      corridor[2*DIM+3] = 1'b0;
      corridor[3*DIM+3] = 1'b0;
      map = corridor;
      rst_sys = 1'b0;
      drive(N, 1'b0);

      // WELCOME: up x3, down x5 with saturation at 1
      add(U,0, 0,2,0,0, 1,1,0,0,0);
      add(N,0, 0,2,0,0, 1,1,0,0,0);
      add(U,0, 0,3,0,0, 1,1,0,0,0);
      add(N,0, 0,3,0,0, 1,1,0,0,0);
      add(U,0, 0,4,0,0, 1,1,0,0,0);
      add(N,0, 0,4,0,0, 1,1,0,0,0);
      add(D,0, 0,3,0,0, 1,1,0,0,0);
      add(N,0, 0,3,0,0, 1,1,0,0,0);
      add(D,0, 0,2,0,0, 1,1,0,0,0);
      add(N,0, 0,2,0,0, 1,1,0,0,0);
      for (int i = 0; i < 3; i++) begin
         add(D,0, 0,1,0,0, 1,1,0,0,0);
         add(N,0, 0,1,0,0, 1,1,0,0,0);
      end
      // enter in WELCOME, enter in GEN
      add(E,0, 1,1,1,0, 1,1,0,0,0);
      add(N,0, 1,1,0,0, 1,1,0,0,0);
      add(E,0, 1,1,1,0, 1,1,0,0,0);
      add(N,0, 1,1,0,0, 1,1,0,0,0);
      // GEN: no map yet, then valid map
      add(R,0, 1,1,0,0, 1,1,0,0,0);
      add(N,1, 1,1,0,0, 1,1,0,0,0);
      add(R,1, 2,1,0,1, 1,1,0,0,0);
      add(R,1, 2,1,0,1, 2,1,1,0,0);
      for (int i = 0; i < 3; i++) add(R,1, 2,1,0,1, 2,1,1,0,0);
      add(R,1, 2,1,0,1, 3,1,2,0,0);
      for (int i = 0; i < 2; i++) add(R,1, 2,1,0,1, 3,1,2,0,0);
      for (int i = 0; i < 6; i++) add(R,1, 2,1,0,1, 3,1,2,1,0);
      add(N,1, 2,1,0,1, 3,1,2,1,0);
      add(D,1, 2,1,0,1, 3,2,3,1,0);
      for (int i = 0; i < 3; i++) add(D,1, 2,1,0,1, 3,2,3,2,0);
      add(D,1, 2,1,0,1, 3,3,4,2,0);
      add(D,1, 3,1,0,1, 3,3,4,2,1);
      add(N,1, 3,1,0,1, 3,3,4,2,0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst state", 32'(state), 32'd0);
      chk("rst num", 32'(num), 32'd1);
      chk("rst regen", 32'(regen), 32'd0);
      chk("rst lock", 32'(map_locked), 32'd0);
      chk("rst x", 32'(pos_x), 32'd1);
      chk("rst y", 32'(pos_y), 32'd1);
      chk("rst step", 32'(step_cnt), 32'd0);
      chk("rst sec", 32'(play_sec), 32'd0);
      chk("rst win", 32'(win), 32'd0);
      rst_sys = 1'b1;
      tick(N, 1'b0);

      foreach (tv[i]) begin
         tick(tv[i].k, tv[i].mv);
         chk($sformatf("v%0d state", i), 32'(state), 32'(tv[i].st));
         chk($sformatf("v%0d num", i), 32'(num), 32'(tv[i].num));
         chk($sformatf("v%0d regen", i), 32'(regen), 32'(tv[i].rg));
         chk($sformatf("v%0d lock", i), 32'(map_locked), 32'(tv[i].lk));
         chk($sformatf("v%0d x", i), 32'(pos_x), 32'(tv[i].x));
         chk($sformatf("v%0d y", i), 32'(pos_y), 32'(tv[i].y));
         chk($sformatf("v%0d step", i), 32'(step_cnt), 32'(tv[i].step));
         chk($sformatf("v%0d sec", i), 32'(play_sec), 32'(tv[i].sec));
         chk($sformatf("v%0d win", i), 32'(win), 32'(tv[i].win));
      end

      // live map changes in WIN are ignored
      map = '0;
      tick(N, 1'b1);
      chk_pos("win live", 2'd3, 5'd3, 5'd3, 16'd4);
      chk("win live lock", 32'(map_locked), 32'd1);
      map = corridor;

      // WIN -> GEN on enter; score held
      tick(E, 1'b1);
      chk_pos("win enter", 2'd1, 5'd3, 5'd3, 16'd4);
      chk("win enter regen", 32'(regen), 32'd1);
      chk("win enter lock", 32'(map_locked), 32'd0);
      chk("win enter sec", 32'(play_sec), 32'd2);
      tick(N, 1'b1);
      chk("gen regen end", 32'(regen), 32'd0);

      // enter and direction together in GEN: enter wins
      tick(E | R, 1'b1);
      chk("gen both state", 32'(state), 32'd1);
      chk("gen both regen", 32'(regen), 32'd1);
      tick(N, 1'b1);
      tick(R, 1'b1);
      chk_pos("replay", 2'd2, 5'd1, 5'd1, 16'd0);
      chk("replay sec", 32'(play_sec), 32'd0);

      // open live map must not unblock the latched wall below (1,1)
      map = '0;
      tick(D, 1'b1);
      chk_pos("wall d1", 2'd2, 5'd1, 5'd1, 16'd0);
      tick(D, 1'b1);
      chk_pos("wall d2", 2'd2, 5'd1, 5'd1, 16'd0);
      tick(N, 1'b1);
      tick(R, 1'b1);
      chk_pos("replay r", 2'd2, 5'd2, 5'd1, 16'd1);
      map = corridor;

      // async reset mid-PLAY, up held across release
      drive(U, 1'b1);
      rst_sys = 1'b0;
      #2;
      chk_pos("midrst", 2'd0, 5'd1, 5'd1, 16'd0);
      chk("midrst lock", 32'(map_locked), 32'd0);
      chk("midrst sec", 32'(play_sec), 32'd0);
      @(posedge clk);
      #1;
      rst_sys = 1'b1;
      repeat (3) tick(U, 1'b1);
      chk("held up num", 32'(num), 32'd1);
      chk("held up state", 32'(state), 32'd0);
      chk("held up regen", 32'(regen), 32'd0);
      tick(N, 1'b1);
      tick(U, 1'b1);
      chk("fresh up num", 32'(num), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Parametrised game-control core for the maze top.
- Owns the WELCOME/GEN/PLAY/WIN flow, the size selector `num`, the regenerate request to the map generator, the locked copy of the map, and the player position with rate-limited, wall-checked moves.
- Sits between the PS2 key decoder and the map generator/graphics blocks.
- Generalises the fixed 19x19 flow to any odd MAZE_DIM, adds auto-repeat movement, a step counter and a saturating play timer.

Parameters:
- MAZE_DIM, 19, maze edge length in cells (odd, 5..31); map is MAZE_DIM*MAZE_DIM bits.
- POS_W, 5, position coordinate width; must satisfy 2^POS_W > MAZE_DIM.
- MOVE_TICKS, 50_000_000, clk cycles between repeated moves while a direction key is held (0.5 s at 100 MHz).
- SEC_TICKS, 100_000_000, clk cycles per timer second.
- NUM_MIN, 1, smallest selectable `num`.
- NUM_MAX, 20, largest selectable `num`.

Ports:
- clk  in  1  system clock
- rst_sys  in  1  asynchronous, active-low reset
- key_up  in  1  level, high while the key is held (PS2 domain already synchronised)
- key_down  in  1  level, as key_up
- key_left  in  1  level, as key_up
- key_right  in  1  level, as key_up
- key_enter  in  1  level, as key_up
- map  in  MAZE_DIM*MAZE_DIM  generator map; bit index y*MAZE_DIM+x; 1 = wall
- map_valid  in  1  generator map stable
- state  out  2  0 WELCOME, 1 GEN, 2 PLAY, 3 WIN
- num  out  5  selected difficulty/seed number
- regen  out  1  one-cycle request for a new map
- map_locked  out  1  high in PLAY and WIN
- pos_x  out  POS_W  player column
- pos_y  out  POS_W  player row
- step_cnt  out  16  accepted moves, saturating at 0xFFFF
- play_sec  out  12  seconds spent in PLAY, saturating at 4095
- win  out  1  one-cycle pulse on entering WIN

Behaviour:
- Reset (async assert, sync release): state=WELCOME, num=NUM_MIN, regen=0, map_locked=0, pos=(1,1), step_cnt=0, play_sec=0, win=0, all edge-detect registers=0, internal map copy=0.
- Edge detect: each key is registered; "press" = current & ~previous. A key held through reset release is not a press.
- WELCOME:
  - up press: num+1, saturating at NUM_MAX.
  - down press: num-1, saturating at NUM_MIN.
  - enter press: regen=1 for that cycle, go to GEN.
- GEN:
  - enter press: regen pulse, stay in GEN.
  - Any direction press while map_valid=1: latch map into the internal copy, pos=(1,1), step_cnt=0, play_sec=0, repeat counter=0, go to PLAY.
  - Direction press while map_valid=0: ignored.
- PLAY:
  - Direction resolution: held direction chosen by priority up>down>left>right.
  - Move timing: move attempt when repeat counter==0 and a direction is held. Counter then reloads MOVE_TICKS-1 and decrements every cycle while any direction is held. Counter is forced to 0 when no direction is held, so a fresh press moves on the next cycle.
  - Move attempt: target = pos ±1 on one axis. Rejected if the target is outside 0..MAZE_DIM-1 or the latched map bit is 1. Rejected attempts leave pos and step_cnt unchanged but still reload the counter.
  - Accepted move: pos updates the cycle after the attempt; step_cnt+1 (saturating).
  - Timer: play_sec increments every SEC_TICKS cycles in PLAY.
  - enter is ignored in PLAY.
- Goal: when pos == (MAZE_DIM-2, MAZE_DIM-2), the next cycle goes to WIN and win=1 for one cycle. step_cnt and play_sec freeze.
- WIN: enter press gives a regen pulse, map_locked=0, go to GEN. pos, step_cnt and play_sec hold until the next PLAY entry.
- Live `map` changes in PLAY/WIN have no effect; only the latched copy is used.
- Simultaneous enter and direction press in GEN: enter wins (regen, stay in GEN).
- Reset mid-PLAY returns everything to reset values within the same cycle.

Decomposition:
- Package maze_pkg: state encoding localparams (ST_WELCOME..ST_WIN), direction encoding, START_X/START_Y=1, goal-coordinate function of MAZE_DIM.
- One sub-module, maze_move_unit: holds the repeat counter, priority resolve, bounds and wall check, and pos/step_cnt registers. Its inputs are the latched map, the held direction, and a play-enable/load pulse.

Test Plan (MAZE_DIM=5, MOVE_TICKS=4, SEC_TICKS=8; corridor map with walls everywhere except (1,1),(2,1),(3,1),(3,2),(3,3)):
- Reset, 3 up presses, 5 down presses in WELCOME -> num 1→4→1 (saturates at 1); no regen.
- Enter in WELCOME, then enter in GEN -> regen pulses exactly one cycle each; state 0→1→1.
- GEN with map_valid=0, right press -> stays GEN. Raise map_valid, right press -> PLAY, map_locked=1, pos (2,1) the cycle after the first PLAY cycle, step_cnt=1.
- Hold right 12 cycles from (2,1) -> pos (3,1) after 4 cycles; further attempts into wall (4,1) rejected; step_cnt stays 2.
- Hold down from (3,1) -> (3,2) then (3,3) = goal; WIN next cycle, win high one cycle, step_cnt=4. Toggle the live map afterwards -> no change. Enter -> GEN, regen pulse.
- Assert rst_sys low mid-PLAY -> pos (1,1), state WELCOME, step_cnt 0 immediately. Hold up across reset release -> no num change.
